// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write arbiter bus: CPU and image-loader write requesters, fill control, framebuffer write port.
// Latency: n/a (signal bundle only).
// Backpressure: valid/ready per requester; readies are driven by the arbiter (slave side).
// Ports: cpu_* / ldr_* requester handshakes, clr_* fill control and status, fb_* registered write port.
interface fb_write_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
);
    logic              cpu_valid;
    logic              cpu_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;

    logic              ldr_valid;
    logic              ldr_ready;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_data;

    logic              clr_start;
    logic [DATA_W-1:0] clr_value;
    logic              clr_busy;
    logic              clr_done;

    logic              fb_we;
    logic [ADDR_W-1:0] fb_waddr;
    logic [DATA_W-1:0] fb_din;

    // Requester / controller side.
    modport master (
        output cpu_valid, cpu_addr, cpu_data,
        output ldr_valid, ldr_addr, ldr_data,
        output clr_start, clr_value,
        input  cpu_ready, ldr_ready,
        input  clr_busy, clr_done,
        input  fb_we, fb_waddr, fb_din
    );

    // Arbiter side.
    modport slave (
        input  cpu_valid, cpu_addr, cpu_data,
        input  ldr_valid, ldr_addr, ldr_data,
        input  clr_start, clr_value,
        output cpu_ready, ldr_ready,
        output clr_busy, clr_done,
        output fb_we, fb_waddr, fb_din
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter of CPU and loader pixel writes onto one framebuffer port, plus a whole-buffer fill engine.
// Latency: 1 cycle from a completed handshake (or fill step) to fb_we/fb_waddr/fb_din.
// Backpressure: readies drop while a fill is requested or running; a losing or blocked requester stalls with data held.
// Ports: clk, rst (async, active-high); bus (slave modport) carries cpu_*, ldr_*, clr_*, fb_* signals.
module fb_write_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    fb_write_arbiter_if.slave    bus
);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_clr_val;
    logic              r_busy;
    logic              r_done;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_din;
    // 1 = loader was served by the last completed transfer, so the CPU wins the next contention.
    logic              r_last_ldr;

    logic w_block;
    logic w_cpu_rdy;
    logic w_ldr_rdy;
    logic w_cpu_xfer;
    logic w_ldr_xfer;

    // A fill request on this very cycle also blocks, so a same-cycle valid never slips in ahead of the fill.
    assign w_block    = bus.clr_start | r_busy;
    assign w_cpu_rdy  = ~w_block & bus.cpu_valid & (~bus.ldr_valid |  r_last_ldr);
    assign w_ldr_rdy  = ~w_block & bus.ldr_valid & (~bus.cpu_valid | ~r_last_ldr);
    assign w_cpu_xfer = bus.cpu_valid & w_cpu_rdy;
    assign w_ldr_xfer = bus.ldr_valid & w_ldr_rdy;

    assign bus.cpu_ready = w_cpu_rdy;
    assign bus.ldr_ready = w_ldr_rdy;
    assign bus.clr_busy  = r_busy;
    assign bus.clr_done  = r_done;
    assign bus.fb_we     = r_we;
    assign bus.fb_waddr  = r_waddr;
    assign bus.fb_din    = r_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_clr_val  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_din      <= '0;
            r_last_ldr <= 1'b1;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.clr_start) begin
                        r_state   <= S_CLEAR;
                        r_busy    <= 1'b1;
                        r_clr_val <= bus.clr_value;
                        r_cnt     <= '0;
                    end else if (w_cpu_xfer) begin
                        r_we       <= 1'b1;
                        r_waddr    <= bus.cpu_addr;
                        r_din      <= bus.cpu_data;
                        r_last_ldr <= 1'b0;
                    end else if (w_ldr_xfer) begin
                        r_we       <= 1'b1;
                        r_waddr    <= bus.ldr_addr;
                        r_din      <= bus.ldr_data;
                        r_last_ldr <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // clr_start is deliberately not looked at here: a running fill cannot be restarted.
                    r_we    <= 1'b1;
                    r_waddr <= ADDR_W'(r_cnt);
                    r_din   <= r_clr_val;
                    if (r_cnt == CNT_LAST) begin
                        // Last word goes out on the same edge that ends the fill, so busy spans exactly DEPTH cycles.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
